// File: rtl/mmio_pkg.sv
// Shared constants for the dmem MMIO bridge: window offsets, CTRL bit layout, default base.
package mmio_pkg;

  // Offsets of the counter and CTRL registers are relative to NUM_PROBES.
  localparam int MMIO_OFF_CNT  = 0;
  localparam int MMIO_OFF_CTRL = 1;

  localparam int CTRL_CNT_EN  = 0;
  localparam int CTRL_CNT_CLR = 1;

  localparam logic [11:0] MMIO_BASE_DEFAULT = 12'hF00;

  function automatic int mmio_abs_off(input int num_probes, input int rel_off);
    return num_probes + rel_off;
  endfunction

endpackage

// File: rtl/mmio_cycle_counter.sv
// Free-running wrap-around cycle counter with enable and synchronous clear (clear wins).
module mmio_cycle_counter #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  output logic [DATA_W-1:0] count
);

  logic [DATA_W-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + DATA_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/mmio_bridge.sv
// dmem front end decoding an MMIO window of probe registers and an optional cycle counter.
// Define MMIO_CYCLE_COUNTER_EN to build the counter and its CTRL register.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int                ADDR_W     = 12,
  parameter int                DATA_W     = 32,
  parameter int                NUM_PROBES = 4,
  parameter logic [ADDR_W-1:0] MMIO_BASE  = ADDR_W'(MMIO_BASE_DEFAULT)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            cpu_address,
  input  logic [DATA_W-1:0]            cpu_data,
  input  logic                         cpu_wren,
  output logic [DATA_W-1:0]            cpu_q,
  output logic [ADDR_W-1:0]            mem_address,
  output logic [DATA_W-1:0]            mem_data,
  output logic                         mem_wren,
  input  logic [DATA_W-1:0]            mem_q,
  output logic [NUM_PROBES*DATA_W-1:0] probe,
  output logic [NUM_PROBES-1:0]        probe_strobe
);

  localparam logic [ADDR_W-1:0] L_OFF_CNT  = ADDR_W'(mmio_abs_off(NUM_PROBES, MMIO_OFF_CNT));
  localparam logic [ADDR_W-1:0] L_OFF_CTRL = ADDR_W'(mmio_abs_off(NUM_PROBES, MMIO_OFF_CTRL));

  logic              w_is_mmio;
  logic [ADDR_W-1:0] w_off;
  logic              w_mmio_wr;
  logic [DATA_W-1:0] w_mmio_q;

  logic [DATA_W-1:0]     r_probe [NUM_PROBES];
  logic [NUM_PROBES-1:0] r_strobe;
  logic [NUM_PROBES-1:0] w_probe_sel;

  assign w_is_mmio = (cpu_address >= MMIO_BASE);
  assign w_off     = cpu_address - MMIO_BASE;
  assign w_mmio_wr = cpu_wren & w_is_mmio;

  assign mem_address = cpu_address;
  assign mem_data    = cpu_data;
  assign mem_wren    = cpu_wren & ~w_is_mmio;

  for (genvar gi = 0; gi < NUM_PROBES; gi++) begin : g_probe
    assign w_probe_sel[gi]                = w_mmio_wr && (w_off == ADDR_W'(gi));
    assign probe[gi*DATA_W +: DATA_W]     = r_probe[gi];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PROBES; i++) begin
        r_probe[i] <= '0;
      end
      r_strobe <= '0;
    end else begin
      for (int i = 0; i < NUM_PROBES; i++) begin
        if (w_probe_sel[i]) begin
          r_probe[i] <= cpu_data;
        end
      end
      r_strobe <= w_probe_sel;
    end
  end

  assign probe_strobe = r_strobe;

`ifdef MMIO_CYCLE_COUNTER_EN
  logic              r_cnt_en;
  logic              w_ctrl_wr;
  logic              w_cnt_en_next;
  logic              w_cnt_clr;
  logic [DATA_W-1:0] w_count;

  // The enable being written already governs the counter on the write edge.
  assign w_ctrl_wr     = w_mmio_wr && (w_off == L_OFF_CTRL);
  assign w_cnt_en_next = w_ctrl_wr ? cpu_data[CTRL_CNT_EN] : r_cnt_en;
  assign w_cnt_clr     = w_ctrl_wr && cpu_data[CTRL_CNT_CLR];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt_en <= 1'b1;
    end else begin
      r_cnt_en <= w_cnt_en_next;
    end
  end

  mmio_cycle_counter #(
    .DATA_W(DATA_W)
  ) u_cycle_counter (
    .clock(clock),
    .reset(reset),
    .en   (w_cnt_en_next),
    .clr  (w_cnt_clr),
    .count(w_count)
  );
`endif

  always_comb begin
    w_mmio_q = '0;
    for (int i = 0; i < NUM_PROBES; i++) begin
      if (w_off == ADDR_W'(i)) begin
        w_mmio_q = r_probe[i];
      end
    end
`ifdef MMIO_CYCLE_COUNTER_EN
    if (w_off == L_OFF_CNT) begin
      w_mmio_q = w_count;
    end
    if (w_off == L_OFF_CTRL) begin
      w_mmio_q              = '0;
      w_mmio_q[CTRL_CNT_EN] = r_cnt_en;
    end
`endif
  end

  assign cpu_q = w_is_mmio ? w_mmio_q : mem_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed plus random bench for mmio_bridge against a register-map reference model.
module tb_mmio_bridge;

  localparam int          AW   = 12;
  localparam int          DW   = 32;
  localparam int          NP   = 4;
  localparam logic [11:0] BASE = 12'hF00;

  logic              clock = 1'b0;
  logic              reset;
  logic [AW-1:0]     cpu_address;
  logic [DW-1:0]     cpu_data;
  logic              cpu_wren;
  logic [DW-1:0]     cpu_q;
  logic [AW-1:0]     mem_address;
  logic [DW-1:0]     mem_data;
  logic              mem_wren;
  logic [DW-1:0]     mem_q;
  logic [NP*DW-1:0]  probe;
  logic [NP-1:0]     probe_strobe;

  mmio_bridge #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_PROBES(NP), .MMIO_BASE(BASE)
  ) dut (
    .clock(clock), .reset(reset),
    .cpu_address(cpu_address), .cpu_data(cpu_data), .cpu_wren(cpu_wren), .cpu_q(cpu_q),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
    .probe(probe), .probe_strobe(probe_strobe)
  );

  always #5 clock = ~clock;

  // Bench-side dmem driven by the DUT's mem_* outputs, same-cycle read.
  logic [DW-1:0] sram [1 << AW];
  assign mem_q = sram[mem_address];
  always @(posedge clock) if (mem_wren) sram[mem_address] <= mem_data;

  // Reference model state.
  logic [DW-1:0] dm_m    [1 << AW];
  logic [DW-1:0] probe_m [NP];
  logic [NP-1:0] strobe_m;
  logic [DW-1:0] cnt_m;
  logic          en_m;

  int errors = 0;
  int checks = 0;
  int txn    = 0;
  logic [DW-1:0]    last_q;
  logic [NP*DW-1:0] last_probe;
  logic [NP-1:0]    last_strobe;
  logic [DW-1:0]    qa, qb;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_q(input logic [AW-1:0] a);
    int off;
    if (a < BASE) return dm_m[a];
    off = int'(a) - int'(BASE);
    if (off < NP) return probe_m[off];
`ifdef MMIO_CYCLE_COUNTER_EN
    if (off == NP)     return cnt_m;
    if (off == NP + 1) return {31'b0, en_m};
`endif
    return '0;
  endfunction

  function automatic logic [NP*DW-1:0] exp_probe();
    logic [NP*DW-1:0] v;
    for (int i = 0; i < NP; i++) v[i*DW +: DW] = probe_m[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) probe_m[i] = '0;
    strobe_m = '0;
    cnt_m    = '0;
    en_m     = 1'b1;
  endtask

  // One bus cycle: drive, check mid-cycle, then advance the model on the edge.
  task automatic step(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
    int   off;
    logic new_en, clr;
    cpu_address = a;
    cpu_data    = d;
    cpu_wren    = w;
    @(negedge clock);
    chk("mem_address", mem_address, a);
    chk("mem_data", mem_data, d);
    chk("mem_wren", mem_wren, w && (a < BASE));
    chk("cpu_q", cpu_q, exp_q(a));
    chk("probe", probe, exp_probe());
    chk("probe_strobe", probe_strobe, strobe_m);
    last_q      = cpu_q;
    last_probe  = probe;
    last_strobe = probe_strobe;
    $display("txn %0d addr=%h wr=%b data=%h q=%h strobe=%b", txn, a, w, d, cpu_q, probe_strobe);
    txn++;
    @(posedge clock);
    off      = int'(a) - int'(BASE);
    strobe_m = '0;
    if (w && a < BASE) dm_m[a] = d;
    if (w && a >= BASE && off < NP) begin
      probe_m[off]  = d;
      strobe_m[off] = 1'b1;
    end
    new_en = en_m;
    clr    = 1'b0;
    if (w && a >= BASE && off == NP + 1) begin
      new_en = d[0];
      clr    = d[1];
    end
`ifdef MMIO_CYCLE_COUNTER_EN
    if (clr)         cnt_m = '0;
    else if (new_en) cnt_m = cnt_m + 1;
    en_m = new_en;
`endif
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_probe"}, probe, '0);
    chk({tag, "_strobe"}, probe_strobe, '0);
    cpu_address = BASE + 12'(NP);
    #1;
    chk({tag, "_cnt"}, cpu_q, '0);
    cpu_address = BASE + 12'(NP + 1);
    #1;
`ifdef MMIO_CYCLE_COUNTER_EN
    chk({tag, "_ctrl"}, cpu_q, 32'h1);
`else
    chk({tag, "_ctrl"}, cpu_q, 32'h0);
`endif
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      sram[i] = '0;
      dm_m[i] = '0;
    end
    model_reset();
    reset = 1'b1; cpu_address = '0; cpu_data = '0; cpu_wren = 1'b0;
    #2;
    check_reset_state("por");
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    step(12'h010, 32'hDEADBEEF, 1'b1);
    step(12'h010, 32'h0, 1'b0);
    chk("dmem_readback", last_q, 32'hDEADBEEF);

    step(12'hF01, 32'h12345678, 1'b1);
    step(12'hF01, 32'h0, 1'b0);
    chk("probe1_value", last_probe[63:32], 32'h12345678);
    chk("probe1_strobe", last_strobe, 4'b0010);
    chk("probe1_read", last_q, 32'h12345678);
    step(12'hF01, 32'h0, 1'b0);
    chk("probe1_strobe_drop", last_strobe, 4'b0000);

    step(12'hF02, 32'h1, 1'b1);
    step(12'hF02, 32'h2, 1'b1);
    step(12'hF02, 32'h0, 1'b0);
    chk("b2b_strobe", last_strobe, 4'b0100);

`ifdef MMIO_CYCLE_COUNTER_EN
    step(12'hF04, 32'h0, 1'b0);
    qa = last_q;
    repeat (4) step(12'h000, 32'h0, 1'b0);
    step(12'hF04, 32'h0, 1'b0);
    qb = last_q;
    chk("cnt_delta5", qb - qa, 32'd5);

    step(12'hF05, 32'h0, 1'b1);
    step(12'hF04, 32'h0, 1'b0);
    qa = last_q;
    repeat (4) step(12'h000, 32'h0, 1'b0);
    step(12'hF04, 32'h0, 1'b0);
    qb = last_q;
    chk("cnt_frozen", qb, qa);

    step(12'hF05, 32'h3, 1'b1);
    step(12'hF04, 32'h0, 1'b0);
    chk("cnt_clr0", last_q, 32'd0);
    step(12'hF04, 32'h0, 1'b0);
    chk("cnt_clr1", last_q, 32'd1);
    step(12'hF05, 32'h0, 1'b0);
    chk("ctrl_read", last_q, 32'h1);
`else
    step(12'hF04, 32'hFFFFFFFF, 1'b1);
    step(12'hF05, 32'hFFFFFFFF, 1'b1);
    step(12'hF04, 32'h0, 1'b0);
    chk("nocnt_f04", last_q, 32'h0);
    step(12'hF05, 32'h0, 1'b0);
    chk("nocnt_f05", last_q, 32'h0);
`endif

    step(12'hF06, 32'h0, 1'b0);
    chk("f06_zero", last_q, 32'h0);
    step(12'hFFF, 32'hFFFFFFFF, 1'b1);
    chk("fff_zero", last_q, 32'h0);
    step(12'hFFF, 32'h0, 1'b0);
    chk("fff_no_strobe", last_strobe, 4'b0000);
    step(12'hEFF, 32'hCAFEF00D, 1'b1);
    step(12'hEFF, 32'h0, 1'b0);
    chk("eff_dmem", last_q, 32'hCAFEF00D);
    step(12'hF00, 32'h0BADF00D, 1'b1);
    step(12'hF00, 32'h0, 1'b0);
    chk("f00_probe0", last_q, 32'h0BADF00D);

    // Asynchronous reset asserted mid-cycle right after a probe write.
    step(12'hF03, 32'h55AA55AA, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_reset_state("async");
    model_reset();
    @(posedge clock);
    #2 reset = 1'b0;

    for (int n = 0; n < 300; n++) begin
      logic [AW-1:0] a;
      case ($urandom_range(0, 3))
        0:       a = BASE + 12'($urandom_range(0, 7));
        1:       a = 12'($urandom_range(0, 15));
        2:       a = 12'($urandom);
        default: begin
          case ($urandom_range(0, 2))
            0:       a = 12'hEFF;
            1:       a = 12'hF00;
            default: a = 12'hFFF;
          endcase
        end
      endcase
      step(a, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_bridge.md
# mmio_bridge

Parametrised data-memory front end between the processor's dmem port and the dmem syncram. It decodes a memory-mapped I/O window at the top of the data address space. Inside that window it provides NUM_PROBES software-writable probe registers and a free-running cycle counter. This generalises the single fixed probe output of the current top level. Ordinary dmem traffic passes through unchanged; MMIO accesses never reach dmem.

## Interface
Parameters:
- ADDR_W, 12, dmem word-address width
- DATA_W, 32, data width
- NUM_PROBES, 4, number of probe registers (1..16)
- MMIO_BASE, 12'hF00, first word address of the MMIO window; the window runs to 2^ADDR_W-1

Ports:
- clock  in  1  master clock, rising edge
- reset  in  1  asynchronous, active-high
- cpu_address  in  ADDR_W  processor dmem address
- cpu_data  in  DATA_W  processor write data
- cpu_wren  in  1  processor write enable
- cpu_q  out  DATA_W  read data returned to processor
- mem_address  out  ADDR_W  to dmem
- mem_data  out  DATA_W  to dmem
- mem_wren  out  1  to dmem
- mem_q  in  DATA_W  from dmem
- probe  out  NUM_PROBES*DATA_W  concatenated probe registers; probe 0 in the LSBs
- probe_strobe  out  NUM_PROBES  one-cycle pulse per probe after it is written

## Operation
- is_mmio = (cpu_address >= MMIO_BASE). off = cpu_address - MMIO_BASE.
- mem_address and mem_data always equal cpu_address and cpu_data.
- mem_wren = cpu_wren & ~is_mmio. MMIO writes never corrupt dmem.
- MMIO map, by word offset:
  - 0..NUM_PROBES-1: probe[i], read/write.
  - NUM_PROBES: cycle counter, read-only. Writes are ignored.
  - NUM_PROBES+1: CTRL. Bit0 = cnt_en, read/write, reset 1. Bit1 = cnt_clr, write-1, self-clearing, reads 0.
  - All other offsets read 0. Writes to them are ignored.
- cpu_q:
  - If is_mmio: the MMIO register selected by the current cpu_address. This is combinational from registered state.
  - Otherwise: mem_q. This matches dmem's inverted-clock, same-cycle read behaviour.
- Probe write: on the rising edge with cpu_wren & is_mmio & off==i:
  - probe[i] <= cpu_data.
  - probe_strobe[i] is high for the following cycle only.
- Counter:
  - Increments by 1 each cycle while cnt_en=1.
  - Wraps from 2^DATA_W-1 to 0.
  - A write with cnt_clr=1 sets it to 0 on that edge. Clear wins over increment.
  - cnt_en takes effect from the same edge.
- Reset (asynchronous, any time, including mid-write):
  - All probes 0, probe_strobe 0, counter 0, cnt_en 1.
  - cpu_q during reset follows its mux using the reset register values.

## Timing
- Pass-through path: zero latency, purely combinational.
- MMIO read: data is valid in the same cycle the address is presented. A read after a write to the same register returns the new value starting the cycle after the write edge.
- Write-then-strobe latency: 1 cycle. Back-to-back writes to the same probe keep its strobe high on consecutive cycles.
- Read of the counter returns its value before the current edge's increment.
- Address MMIO_BASE-1 is dmem. Address MMIO_BASE is probe 0. The last window address is 2^ADDR_W-1, with no wrap.

## Configuration
- MMIO_CYCLE_COUNTER_EN defined: counter and CTRL are present as specified.
- MMIO_CYCLE_COUNTER_EN undefined:
  - No counter flops are built.
  - Offsets NUM_PROBES and NUM_PROBES+1 read 0.
  - Writes to those offsets are ignored.
  - Probes are unaffected.

## Structure
- Shared package/header mmio_pkg:
  - Offset constants MMIO_OFF_CNT and MMIO_OFF_CTRL, expressed relative to NUM_PROBES.
  - CTRL bit indices CTRL_CNT_EN and CTRL_CNT_CLR.
  - Default MMIO_BASE.
- One sub-module, mmio_cycle_counter (DATA_W; inputs en and clr; output count). It is instantiated only under MMIO_CYCLE_COUNTER_EN.
- Decode, probe bank and read mux stay in mmio_bridge.

## Test plan
- Write 0xDEADBEEF to dmem address 0x010, then read it back. Expect mem_wren=1 on the write and cpu_q=0xDEADBEEF on the read.
- Write 0x12345678 to 0xF01.
  - Expect mem_wren=0 and probe[63:32]=0x12345678 after the edge.
  - Expect probe_strobe=4'b0010 for exactly one cycle.
  - Reading 0xF01 returns 0x12345678.
- Let reset release with no writes.
  - Reading 0xF04 twice, 5 cycles apart, differs by 5.
  - Write CTRL=0x0; reading twice, 5 cycles apart, returns equal values.
  - Write CTRL=0x3; the next cycle reads 0 and the following cycle reads 1.
- Reads of 0xF06 and 0xFFF return 0. A write of 0xFFFFFFFF to 0xFFF changes no probe and asserts no mem_wren. Address 0xEFF still reaches dmem.
- Assert reset asynchronously mid-cycle after probes were written. Expect probe=0, probe_strobe=0, counter=0 and CTRL read=0x1 immediately, without waiting for a clock edge.
- Build without MMIO_CYCLE_COUNTER_EN. Reads of 0xF04 and 0xF05 return 0 while probe reads and writes still pass.
